// File: rtl/pc_unit.sv
// pc_unit: registered program counter with next-PC selection, exception redirect/EPC capture
// and a circular return-address stack for return-target prediction.
module pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           stall,
    input  logic                           exc,
    input  logic [2:0]                     NPCOp,
    input  logic [25:0]                    IMM,
    input  logic [31:0]                    Jraddr,
    input  logic                           call,
    input  logic                           ras_flush,
    output logic [31:0]                    pc,
    output logic [31:0]                    npc,
    output logic [31:0]                    epc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_ovf,
    output logic                           ras_miss
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d, epc_q, epc_d, pc4, bra, top;
    logic [AW-1:0] sp_q, sp_d, sp_m1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   ras_q [RAS_DEPTH];
    logic          is_ret, empty, full, adv, upd, push, pop, swap;

    assign pc4   = pc_q + 32'd4;
    assign bra   = pc4 + {{14{IMM[15]}}, IMM[15:0], 2'b00};
    assign sp_m1 = sp_q - AW'(1);
    assign top   = ras_q[sp_m1];
    assign is_ret = NPCOp == 3'b100;
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(RAS_DEPTH);
    assign adv   = exc | ~stall;
    assign upd   = adv & ~exc;
    // call+RET on a non-empty stack replaces the top in place; on an empty stack it is a plain push
    assign push  = upd & call & ~(is_ret & ~empty);
    assign pop   = upd & is_ret & ~call & ~empty;
    assign swap  = upd & is_ret & call & ~empty;

    assign npc = exc ? EXC_VEC :
                 (NPCOp == 3'b001) ? bra :
                 (NPCOp == 3'b010) ? {pc4[31:28], IMM, 2'b00} :
                 (NPCOp == 3'b011) ? Jraddr :
                 is_ret ? (empty ? Jraddr : top) : pc4;

    assign ras_miss  = is_ret & empty & ~exc;
    assign pc        = pc_q;
    assign epc       = epc_q;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;

    always_comb begin
        pc_d  = adv ? npc : pc_q;
        epc_d = exc ? pc_q : epc_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (ras_flush) begin
            sp_d  = '0;
            cnt_d = '0;
        end else if (push) begin
            sp_d  = sp_q + AW'(1);
            cnt_d = full ? cnt_q : cnt_q + CW'(1);
            ovf_d = ovf_q | full;
        end else if (pop) begin
            sp_d  = sp_m1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q  <= RESET_PC;
            epc_q <= '0;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ras_q[sp_q] <= pc4;
        else if (swap)
            ras_q[sp_m1] <= pc4;
    end
endmodule
